// File: rtl/instr_ram_arbiter_pkg.sv
// Shared types and defaults for the instruction-SRAM arbiter.
package instr_ram_pkg;

  localparam int          DATA_W        = 32;
  localparam int          DEF_ADDR_W    = 9;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

  // The control word sits just past the end of the SRAM window.
  function automatic logic [31:0] ctrl_offset(input int addr_w);
    return 32'd4 << addr_w;
  endfunction

  localparam logic [31:0] CTRL_OFFSET = ctrl_offset(DEF_ADDR_W);

  typedef enum logic [1:0] {
    IDLE,
    WB_RD,
    WB_ACK
  } arb_state_t;

endpackage

// File: rtl/instr_ram_arbiter_if.sv
// Wishbone slave-port signal bundle between the management SoC and the arbiter.
interface instr_ram_arbiter_if;
  import instr_ram_pkg::*;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic              wbs_ack_o;
  logic [DATA_W-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/instr_ram_arbiter.sv
// Shares the single-port instruction SRAM between Wishbone (fixed priority) and core fetch.
// Optional fetch lock register enabled by defining INSTR_RAM_ARB_LOCK_EN.
module instr_ram_arbiter
  import instr_ram_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  instr_ram_arbiter_if.slave wb,
  input  logic              core_req_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              ram_csb_o,
  output logic              ram_web_o,
  output logic [3:0]        ram_wmask_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  arb_state_t        state, state_next;
  logic              wb_new;
  logic              ram_hit;
  logic              ctrl_hit;
  logic              wb_issue;
  logic              lock;
  logic [ADDR_W-1:0] wb_word;
  logic              unused_adr;

  // Reset gates the request paths so the macro interface idles while reset is held.
  assign wb_new       = wb.wbs_cyc_i & wb.wbs_stb_i & (state == IDLE) & ~wb_rst_i;
  assign ram_hit      = wb.wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign wb_word      = wb.wbs_adr_i[ADDR_W+1:2];
  assign wb_issue     = wb_new & ram_hit;
  assign unused_adr   = ^wb.wbs_adr_i[1:0];
  assign core_gnt_o   = core_req_i & ~wb_new & ~lock & ~wb_rst_i;
  assign core_rdata_o = ram_dout_i;
  assign wb.wbs_ack_o = (state == WB_ACK);

`ifdef INSTR_RAM_ARB_LOCK_EN
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + ctrl_offset(ADDR_W);

  assign ctrl_hit = wb.wbs_adr_i[31:2] == CTRL_ADDR[31:2];

  // Lock comes out of reset set so the SoC can load the program before the core fetches.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lock <= 1'b1;
    end else if (wb_new & ctrl_hit & wb.wbs_we_i & wb.wbs_sel_i[0]) begin
      lock <= wb.wbs_dat_i[0];
    end
  end
`else
  assign ctrl_hit = 1'b0;
  assign lock     = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    ram_csb_o   = 1'b1;
    ram_web_o   = 1'b1;
    ram_wmask_o = 4'b0000;
    ram_addr_o  = '0;
    ram_din_o   = '0;

    case (state)
      IDLE: begin
        if (wb_new) begin
          state_next = (ram_hit & ~wb.wbs_we_i) ? WB_RD : WB_ACK;
        end
      end
      WB_RD:   state_next = WB_ACK;
      WB_ACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Wishbone and core grant are mutually exclusive by construction of core_gnt_o.
    if (wb_issue) begin
      ram_csb_o  = 1'b0;
      ram_web_o  = ~wb.wbs_we_i;
      ram_addr_o = wb_word;
      if (wb.wbs_we_i) begin
        ram_wmask_o = wb.wbs_sel_i;
        ram_din_o   = wb.wbs_dat_i;
      end
    end else if (core_gnt_o) begin
      ram_csb_o  = 1'b0;
      ram_addr_o = core_addr_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb.wbs_dat_o  <= '0;
      core_rvalid_o <= 1'b0;
    end else begin
      core_rvalid_o <= core_gnt_o;
      if (wb_new & ~ram_hit) begin
        wb.wbs_dat_o <= ctrl_hit ? {{(DATA_W-1){1'b0}}, lock} : '0;
      end else if (state == WB_RD) begin
        wb.wbs_dat_o <= ram_dout_i;
      end
    end
  end

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Self-checking bench for instr_ram_arbiter: SRAM macro model, per-cycle reference model, directed vectors.
// Build with INSTR_RAM_ARB_LOCK_EN defined to exercise the fetch lock register.
module tb_instr_ram_arbiter;

  localparam int          ADDR_W    = 9;
  localparam logic [31:0] BASE      = 32'h3000_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h3000_0800;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              core_req = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic              core_gnt;
  logic              core_rvalid;
  logic [31:0]       core_rdata;
  logic              ram_csb;
  logic              ram_web;
  logic [3:0]        ram_wmask;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  logic [31:0] sram   [512];
  logic [31:0] shadow [512];
  logic        preloaded = 1'b0;
  logic [31:0] core_got [$];

  int checks   = 0;
  int failures = 0;

  instr_ram_arbiter_if wb();

  instr_ram_arbiter dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb            (wb),
    .core_req_i    (core_req),
    .core_addr_i   (core_addr),
    .core_gnt_o    (core_gnt),
    .core_rvalid_o (core_rvalid),
    .core_rdata_o  (core_rdata),
    .ram_csb_o     (ram_csb),
    .ram_web_o     (ram_web),
    .ram_wmask_o   (ram_wmask),
    .ram_addr_o    (ram_addr),
    .ram_din_o     (ram_din),
    .ram_dout_i    (ram_dout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // SRAM macro: one-cycle read latency, byte-masked writes, output holds when idle.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 512; i++) sram[i] = 32'(i * 3);
      preloaded = 1'b1;
    end
    if (ram_csb === 1'b0) begin
      if (ram_web === 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) sram[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
      end else begin
        ram_dout <= sram[ram_addr];
      end
    end
  end

  // Reference model: timeline of Wishbone acks, pending fetch returns and a shadow memory.
  int          cyc_no        = 0;
  int          m_ack_cycle   = -1;
  logic        m_is_read     = 1'b0;
  logic [31:0] m_dat         = '0;
  logic        m_fetch_valid = 1'b0;
  logic [31:0] m_fetch_data  = '0;
`ifdef INSTR_RAM_ARB_LOCK_EN
  logic        m_lock        = 1'b1;
`else
  logic        m_lock        = 1'b0;
`endif

  always @(negedge clk) begin
    logic              idle, start, hit, ctrl, exp_gnt;
    logic [ADDR_W-1:0] word;
    if (cyc_no == 0)
      for (int i = 0; i < 512; i++) shadow[i] = 32'(i * 3);
    if (rst) begin
      checkOutput("rst_ack", wb.wbs_ack_o, 0);
      checkOutput("rst_dat", wb.wbs_dat_o, 0);
      checkOutput("rst_rvalid", core_rvalid, 0);
      checkOutput("rst_gnt", core_gnt, 0);
      checkOutput("rst_csb", ram_csb, 1);
      checkOutput("rst_web", ram_web, 1);
      checkOutput("rst_wmask", ram_wmask, 0);
      checkOutput("rst_addr", ram_addr, 0);
      checkOutput("rst_din", ram_din, 0);
      m_ack_cycle   = -1;
      m_fetch_valid = 1'b0;
`ifdef INSTR_RAM_ARB_LOCK_EN
      m_lock = 1'b1;
`endif
    end else begin
      idle  = (cyc_no > m_ack_cycle);
      start = idle & wb.wbs_cyc_i & wb.wbs_stb_i;
      hit   = (wb.wbs_adr_i - BASE) < 32'd2048;
      word  = ADDR_W'((wb.wbs_adr_i - BASE) >> 2);
`ifdef INSTR_RAM_ARB_LOCK_EN
      ctrl  = (wb.wbs_adr_i & ~32'h3) == CTRL_ADDR;
`else
      ctrl  = 1'b0;
`endif
      checkOutput("wb_ack", wb.wbs_ack_o, cyc_no == m_ack_cycle);
      if (cyc_no == m_ack_cycle && m_is_read) checkOutput("wb_dat", wb.wbs_dat_o, m_dat);
      checkOutput("core_rvalid", core_rvalid, m_fetch_valid);
      if (m_fetch_valid) checkOutput("core_rdata", core_rdata, m_fetch_data);

      exp_gnt = core_req & ~start & ~m_lock;
      checkOutput("core_gnt", core_gnt, exp_gnt);
      m_fetch_valid = exp_gnt;
      if (exp_gnt) m_fetch_data = shadow[core_addr];

      if (start && hit) begin
        checkOutput("ram_csb_wb", ram_csb, 0);
        checkOutput("ram_web_wb", ram_web, !wb.wbs_we_i);
        checkOutput("ram_addr_wb", ram_addr, word);
        if (wb.wbs_we_i) begin
          checkOutput("ram_wmask_wb", ram_wmask, wb.wbs_sel_i);
          checkOutput("ram_din_wb", ram_din, wb.wbs_dat_i);
        end
      end else if (exp_gnt) begin
        checkOutput("ram_csb_core", ram_csb, 0);
        checkOutput("ram_web_core", ram_web, 1);
        checkOutput("ram_addr_core", ram_addr, core_addr);
      end else begin
        checkOutput("ram_csb_idle", ram_csb, 1);
      end

      if (start) begin
        m_is_read = !wb.wbs_we_i;
        if (hit) begin
          m_ack_cycle = cyc_no + (wb.wbs_we_i ? 1 : 2);
          if (wb.wbs_we_i) begin
            for (int b = 0; b < 4; b++)
              if (wb.wbs_sel_i[b]) shadow[word][8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
          end else begin
            m_dat = shadow[word];
          end
        end else begin
          m_ack_cycle = cyc_no + 1;
          m_dat = ctrl ? {31'b0, m_lock} : 32'h0;
          if (ctrl && wb.wbs_we_i && wb.wbs_sel_i[0]) m_lock = wb.wbs_dat_i[0];
        end
      end
    end
    cyc_no++;
  end

  // One Wishbone transfer; reports ack latency from the issue cycle and the issue-cycle RAM port.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output logic [31:0] rdata, output int lat,
                               output logic iss_csb, output logic iss_web,
                               output logic [3:0] iss_wmask, output logic [ADDR_W-1:0] iss_addr);
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
    lat = -1; rdata = '0;
    iss_csb = 1'bx; iss_web = 1'bx; iss_wmask = 'x; iss_addr = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        iss_csb = ram_csb; iss_web = ram_web; iss_wmask = ram_wmask; iss_addr = ram_addr;
      end
      if (wb.wbs_ack_o === 1'b1) begin
        lat = i; rdata = wb.wbs_dat_o;
        break;
      end
    end
    if (lat < 0) checkOutput("wb_ack_timeout", 0, 1);
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  // Fetches n words from base, holding request/address until each grant; span = last - first grant cycle.
  task automatic coreRun(input int base, input int n, output int span);
    int granted = 0, received = 0, first = -1, last = -1, t = 0;
    core_got.delete();
    @(posedge clk); #1;
    core_req = 1'b1; core_addr = ADDR_W'(base);
    while ((granted < n || received < n) && t < 100) begin
      @(negedge clk);
      if (core_rvalid === 1'b1 && received < n) begin
        core_got.push_back(core_rdata);
        received++;
      end
      if (core_gnt === 1'b1 && granted < n) begin
        if (first < 0) first = t;
        last = t;
        granted++;
      end
      t++;
      @(posedge clk); #1;
      if (granted >= n) core_req = 1'b0;
      else core_addr = ADDR_W'(base + granted);
    end
    if (t >= 100) checkOutput("core_timeout", 0, 1);
    core_req = 1'b0;
    span = last - first;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0]       rd;
    int                lat, span;
    logic              i_csb, i_web;
    logic [3:0]        i_wmask;
    logic [ADDR_W-1:0] i_addr;

    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = '0;   wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;
    #1 rst = 1'b1;
    #2;
    checkOutput("init_ack", wb.wbs_ack_o, 0);
    checkOutput("init_csb", ram_csb, 1);
    checkOutput("init_gnt", core_gnt, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

`ifdef INSTR_RAM_ARB_LOCK_EN
    @(posedge clk); #1;
    core_req = 1'b1; core_addr = '0;
    repeat (3) begin @(negedge clk); checkOutput("locked_gnt", core_gnt, 0); end
    @(posedge clk); #1 core_req = 1'b0;
    applyStimulus(0, CTRL_ADDR, 32'h0, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("lock_rd_val", rd, 32'h1);
    applyStimulus(1, CTRL_ADDR, 32'h0, 4'h1, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("lock_wr_lat", lat, 1);
    checkOutput("lock_wr_csb", i_csb, 1);
    applyStimulus(0, CTRL_ADDR, 32'h0, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("unlock_rd_val", rd, 32'h0);
`else
    applyStimulus(0, CTRL_ADDR, 32'h0, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("ctrl_miss_lat", lat, 1);
    checkOutput("ctrl_miss_dat", rd, 32'h0);
    checkOutput("ctrl_miss_csb", i_csb, 1);
`endif

    coreRun(0, 8, span);
    checkOutput("burst_span", span, 7);
    checkOutput("burst_count", core_got.size(), 8);
    for (int i = 0; i < core_got.size(); i++) checkOutput("burst_data", core_got[i], 32'(i * 3));

    applyStimulus(1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("wr_lat", lat, 1);
    checkOutput("wr_csb", i_csb, 0);
    checkOutput("wr_web", i_web, 0);
    checkOutput("wr_wmask", i_wmask, 4'hF);
    checkOutput("wr_addr", i_addr, 4);
    applyStimulus(0, 32'h3000_0010, 32'h0, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("rd_lat", lat, 2);
    checkOutput("rd_dat", rd, 32'hDEAD_BEEF);

    applyStimulus(1, 32'h3000_0010, 32'h0000_AB00, 4'b0010, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("bwr_wmask", i_wmask, 4'b0010);
    applyStimulus(0, 32'h3000_0010, 32'h0, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("bwr_rd_dat", rd, 32'hDEAD_ABEF);

    fork
      coreRun(8, 8, span);
      begin
        repeat (3) @(posedge clk);
        applyStimulus(0, 32'h3000_0010, 32'h0, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
      end
    join
    checkOutput("steal_span", span, 8);
    checkOutput("steal_count", core_got.size(), 8);
    for (int i = 0; i < core_got.size(); i++) checkOutput("steal_data", core_got[i], 32'((8 + i) * 3));
    checkOutput("steal_rd_lat", lat, 2);
    checkOutput("steal_rd_dat", rd, 32'hDEAD_ABEF);

    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = 32'h3000_0020;
    @(posedge clk); #1;
    rst = 1'b1;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    #1;
    checkOutput("abort_ack", wb.wbs_ack_o, 0);
    checkOutput("abort_dat", wb.wbs_dat_o, 0);
    checkOutput("abort_csb", ram_csb, 1);
    checkOutput("abort_rvalid", core_rvalid, 0);
    repeat (3) begin @(negedge clk); checkOutput("abort_no_ack", wb.wbs_ack_o, 0); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin @(negedge clk); checkOutput("post_abort_no_ack", wb.wbs_ack_o, 0); end

`ifdef INSTR_RAM_ARB_LOCK_EN
    @(posedge clk); #1;
    core_req = 1'b1; core_addr = 9'd3;
    repeat (3) begin @(negedge clk); checkOutput("relock_gnt", core_gnt, 0); end
    @(posedge clk); #1 core_req = 1'b0;
`endif

    applyStimulus(0, 32'h3000_1000, 32'h0, 4'hF, rd, lat, i_csb, i_web, i_wmask, i_addr);
    checkOutput("miss_lat", lat, 1);
    checkOutput("miss_dat", rd, 32'h0);
    checkOutput("miss_csb", i_csb, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
